// File: rtl/inst_encoder.sv
// RISC-V immediate encoder: scatters a (format, immediate) pair into a base
// instruction word through a two-stage valid/ready pipeline with range checking.
module inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_type,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [7:0]  err_count
);

  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;

  logic        s1_valid_reg;
  logic [2:0]  s1_type_reg;
  logic [31:0] s1_imm_reg;
  logic [31:0] s1_base_reg;
  logic        s1_err_reg;

  logic        out_valid_reg;
  logic [31:0] out_inst_reg;
  logic        out_err_reg;
  logic [7:0]  err_count_reg;

  logic        in_err;
  logic [31:0] enc_inst;
  logic        s2_load;
  logic        s1_advance;
  logic        in_fire;
  logic        out_fire;

  assign s2_load    = !out_valid_reg || out_ready;
  assign s1_advance = s1_valid_reg && s2_load;
  assign in_ready   = !s1_valid_reg || s1_advance;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid_reg && out_ready;

  // Range check: sign-extension bits must all agree with the top kept bit.
  always_comb begin
    in_err = 1'b0;
    case (in_type)
      TYPE_I, TYPE_S: in_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      TYPE_B:         in_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      TYPE_J:         in_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      TYPE_U:         in_err = |in_imm[11:0];
      default:        in_err = 1'b1;
    endcase
  end

  // Scatter the immediate into the format's bit positions; invalid types pass the base through.
  always_comb begin
    enc_inst = s1_base_reg;
    case (s1_type_reg)
      TYPE_I: enc_inst[31:20] = s1_imm_reg[11:0];
      TYPE_S: begin
        enc_inst[31:25] = s1_imm_reg[11:5];
        enc_inst[11:7]  = s1_imm_reg[4:0];
      end
      TYPE_B: begin
        enc_inst[31]    = s1_imm_reg[12];
        enc_inst[30:25] = s1_imm_reg[10:5];
        enc_inst[11:8]  = s1_imm_reg[4:1];
        enc_inst[7]     = s1_imm_reg[11];
      end
      TYPE_U: enc_inst[31:12] = s1_imm_reg[31:12];
      TYPE_J: begin
        enc_inst[31]    = s1_imm_reg[20];
        enc_inst[30:21] = s1_imm_reg[10:1];
        enc_inst[20]    = s1_imm_reg[11];
        enc_inst[19:12] = s1_imm_reg[19:12];
      end
      default: enc_inst = s1_base_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_type_reg  <= 3'd0;
      s1_imm_reg   <= 32'd0;
      s1_base_reg  <= 32'd0;
      s1_err_reg   <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid_reg <= 1'b1;
        s1_type_reg  <= in_type;
        s1_imm_reg   <= in_imm;
        s1_base_reg  <= in_base;
        s1_err_reg   <= in_err;
      end else if (s1_advance) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_inst_reg  <= 32'd0;
      out_err_reg   <= 1'b0;
    end else if (s2_load) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_inst_reg <= enc_inst;
        out_err_reg  <= s1_err_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_reg <= 8'd0;
    end else if (out_fire && out_err_reg && (err_count_reg != 8'd255)) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_inst  = out_inst_reg;
  assign out_err   = out_err_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: per-format encodings, range errors,
// streaming, backpressure, mid-flight reset and counter saturation.
module tb_inst_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [7:0]  err_count;

  int checks = 0;
  int passes = 0;

  inst_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_imm    (in_imm),
    .in_base   (in_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
      $display("check %s: got 0x%08h ok", tag, obs);
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One isolated word: checks acceptance, one-cycle-later emptiness, then the output.
  task automatic send(input string tag, input logic [2:0] t, input logic [31:0] imm,
                      input logic [31:0] base, input logic [31:0] exp_inst, input logic exp_err);
    in_valid = 1'b1;
    in_type  = t;
    in_imm   = imm;
    in_base  = base;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check({tag, "_not_yet"}, {31'd0, out_valid}, 32'd0);
    step();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_inst"}, out_inst, exp_inst);
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_type = 3'd0; in_imm = 32'd0; in_base = 32'd0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    send("enc_i", 3'd1, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0);
    send("enc_s", 3'd2, 32'h0000_0008, 32'h0020_A023, 32'h0020_A423, 1'b0);
    send("enc_b", 3'd3, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
    send("enc_j", 3'd5, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0);
    send("enc_u", 3'd4, 32'h1234_5000, 32'h0000_02B7, 32'h1234_52B7, 1'b0);

    send("err_i", 3'd1, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1);
    send("err_b", 3'd3, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1);
    send("err_t0", 3'd0, 32'h0000_0005, 32'h0000_0013, 32'h0000_0013, 1'b1);
    step();
    check("err_count_3", {24'd0, err_count}, 32'd3);
    check("drained", {31'd0, out_valid}, 32'd0);

    // Ten back-to-back words: outputs appear two samples after being driven.
    for (int c = 0; c <= 12; c++) begin
      if (c >= 2 && c <= 11) begin
        check($sformatf("stream_valid_%0d", c - 2), {31'd0, out_valid}, 32'd1);
        check($sformatf("stream_inst_%0d", c - 2), out_inst,
              {12'(c - 1), 20'h00013});
      end
      if (c == 12) check("stream_end", {31'd0, out_valid}, 32'd0);
      if (c < 10) begin
        in_valid = 1'b1;
        in_type  = 3'd1;
        in_imm   = 32'(c + 1);
        in_base  = 32'h0000_0013;
        check($sformatf("stream_ready_%0d", c), {31'd0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      step();
    end

    // Backpressure: three words offered, only two fit.
    out_ready = 1'b0;
    in_valid = 1'b1; in_type = 3'd1; in_base = 32'h0000_0013;
    in_imm = 32'h100;
    step();
    in_imm = 32'h200;
    step();
    in_imm = 32'h300;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_in_ready_%0d", k), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_inst_%0d", k), out_inst, 32'h1000_0013);
      check($sformatf("bp_err_%0d", k), {31'd0, out_err}, 32'd0);
      if (k < 2) step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_out1_valid", {31'd0, out_valid}, 32'd1);
    check("bp_out1_inst", out_inst, 32'h2000_0013);
    step();
    check("bp_out2_valid", {31'd0, out_valid}, 32'd1);
    check("bp_out2_inst", out_inst, 32'h3000_0013);
    step();
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_type = 3'd0; in_base = 32'h0000_0013; in_imm = 32'h400;
    step();
    in_imm = 32'h500;
    step();
    in_valid = 1'b0;
    check("full_valid", {31'd0, out_valid}, 32'd1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_count", {24'd0, err_count}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_inst", out_inst, 32'd0);
    step();
    check("mid_rst_no_output", {31'd0, out_valid}, 32'd0);

    // 300 errored words saturate the counter.
    in_valid = 1'b1; in_type = 3'd7; in_base = 32'h0000_0013; in_imm = 32'd0;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        check("sat_mid_valid", {31'd0, out_valid}, 32'd1);
        check("sat_mid_err", {31'd0, out_err}, 32'd1);
      end
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    step();
    check("sat_drained", {31'd0, out_valid}, 32'd0);
    check("sat_count", {24'd0, err_count}, 32'd255);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Streaming RISC-V immediate encoder. It is the inverse of the core's immediate generator: it takes a 32-bit immediate value, an immediate-format select, and a base instruction word. It scatters the immediate into the format's instruction bit positions and range-checks the value. The block feeds the BIOS/test-program loader and the self-check harness, which emit instruction words from `(format, immediate)` pairs. It is a 2-stage valid/ready pipeline with an error flag per word and a saturating error counter.

## Interface
- No parameters.
- `clk` input 1: single clock; everything is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: block accepts the request this cycle.
- `in_type` input 3: format code. 1=I, 2=S, 3=B, 4=U, 5=J; 0, 6, 7 are invalid.
- `in_imm` input 32: immediate value, two's complement.
- `in_base` input 32: instruction word with opcode, rd, rs1, rs2, funct fields. Its immediate bit positions are ignored and overwritten.
- `out_valid` output 1: encoded word valid.
- `out_ready` input 1: consumer accepts the word.
- `out_inst` output 32: encoded instruction.
- `out_err` output 1: the word's immediate was unrepresentable or its type was invalid. Qualified by `out_valid`.
- `err_count` output 8: count of errored words delivered. Saturates at 255.

## Operation
- Transfer rules:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
- Stage 1 (S1) registers `type`, `imm`, `base` and computes `err`.
- Stage 2 (S2) registers the assembled word and `err`. S2 drives `out_*` directly from flops.
- Pipeline control:
  - S2 loads when S2 is empty or S2 transfers out.
  - S1 advances into S2 under the same condition.
  - `in_ready = !s1_valid || s1_advance`. This is combinational and gives full throughput with no bubbles.
- Immediate bit positions replaced per format. All other bits are copied from the base word.
  - I: `inst[31:20] = imm[11:0]`.
  - S: `inst[31:25] = imm[11:5]`; `inst[11:7] = imm[4:0]`.
  - B: `inst[31] = imm[12]`; `inst[30:25] = imm[10:5]`; `inst[11:8] = imm[4:1]`; `inst[7] = imm[11]`.
  - U: `inst[31:12] = imm[31:12]`.
  - J: `inst[31] = imm[20]`; `inst[30:21] = imm[10:1]`; `inst[20] = imm[11]`; `inst[19:12] = imm[19:12]`.
- Range rules. `err` is set on any violation.
  - I, S: `imm[31:11]` are all equal, i.e. the range is -2048..2047.
  - B: `imm[31:12]` are all equal and `imm[0]==0`, i.e. even values in -4096..4094.
  - J: `imm[31:20]` are all equal and `imm[0]==0`.
  - U: `imm[11:0]==0`.
  - Invalid type: `err=1` and `out_inst = in_base` unchanged.
- A range error still emits the truncated encoding; it is never dropped.
- `err_count` increments by 1 on each output transfer with `out_err=1`. It holds at 255.

## Timing
- Reset values: `out_valid=0`, `out_inst=0`, `out_err=0`, `err_count=0`, S1 empty.
- `in_ready` is 1 in the first cycle after reset.
- Reset mid-operation discards both stages with no output. The counter clears.
- Latency: an input accepted at edge N appears on `out_*` after edge N+1, i.e. valid during cycle N+1, provided S2 is free.
- Throughput is one word per cycle while `out_ready=1`.
- Backpressure (`out_ready=0`):
  - S2 holds, and `out_inst` and `out_err` are stable.
  - S1 fills, then `in_ready` drops.
  - At most 2 words are in flight.
- Simultaneous S2 output transfer and S1 advance in the same cycle: S2 reloads with no bubble.
- `out_valid` stays asserted until transferred. Words leave in acceptance order.
- `err_count` updates on the edge of the errored output transfer and is visible the next cycle.

## Test plan
- I type, base 0x00000093, imm 0xFFFFFFFF -> `out_inst` 0xFFF00093, `out_err` 0, valid 2 cycles after the input edge.
- S type, base 0x0020A023, imm 8 -> 0x0020A423. B type, base 0x00000063, imm -4 -> 0xFE000EE3.
- J type, base 0x000000EF, imm 0x800 -> 0x001000EF. U type, base 0x000002B7, imm 0x12345000 -> 0x123452B7.
- Errors: I with imm 2048, then B with imm 3, then type 0 with base 0x13 -> all `out_err` 1. The type-0 word outputs 0x00000013. `err_count` reads 3.
- Back-to-back 10 words with `out_ready=1` -> 10 consecutive `out_valid` cycles. Then `out_ready=0` with 3 pending -> 2 accepted, `in_ready` 0, output stable. Release -> in-order delivery.
- Assert `rst` with both stages full -> next cycle `out_valid` 0, `err_count` 0, `in_ready` 1. 300 errored words -> `err_count` 255.
